// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
// The controller and its 4-bit slice both import this package.
package nibble_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Width of the nibble index; kept at least 1 bit so WIDTH=4 still has a register.
  function automatic int idx_w(input int width);
    int n;
    n = width / NIB_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_slice.sv
// Combinational 4-bit ripple-carry adder slice shared by every nibble step.
// Any inversion of b for subtraction is applied by the controller.
module nibble_addsub_slice
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
    cout = w_c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a single slice,
// LSB first, with valid/ready handshakes on the command and result sides.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int IW  = idx_w(WIDTH);

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_sub;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [IW+1:0]    w_base;
  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_ovf;

  // Nibble selection for the current step; b is inverted here for subtraction.
  always_comb begin
    w_base     = {r_idx, 2'b00};
    w_a_nib    = r_a[w_base +: NIB_W];
    w_b_nib    = r_b[w_base +: NIB_W] ^ {NIB_W{r_sub}};
    w_acc_next = r_acc;
    w_acc_next[w_base +: NIB_W] = w_sum;
    w_last     = (r_idx == IW'(NIB - 1));
    w_ovf      = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) &
                 (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  nibble_addsub_slice u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Partial sums build up in r_acc so the visible result only changes at DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_result <= w_acc_next;
            r_cout   <= w_cout;
            r_ovf    <= w_ovf;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE) & ~rst;
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign result      = r_result;
  assign cout        = r_cout;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for the nibble-serial add/subtract sequencer (WIDTH=16): a cycle-level
// reference model compared every cycle, plus directed literal expectations.
module tb_nibble_serial_addsub_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {ovf, cout, result}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         v;
    beff = s ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, s};
    v    = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // Cycle-level model: phase 0 idle, 1..NIB computing, NIB+1 holding a result.
  int           m_phase;
  logic [W+1:0] m_pend;
  logic [W-1:0] m_res;
  logic         m_cout;
  logic         m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start_valid) begin
        m_pend  <= ref_op(op_a, op_b, sub);
        m_phase <= 1;
      end
    end else if (m_phase <= NIB) begin
      if (m_phase == NIB) begin
        m_res   <= m_pend[W-1:0];
        m_cout  <= m_pend[W];
        m_ovf   <= m_pend[W+1];
      end
      m_phase <= m_phase + 1;
    end else if (res_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_start_ready", {31'b0, start_ready}, {31'b0, (m_phase == 0) && !rst});
      chk("m_busy",        {31'b0, busy},        {31'b0, m_phase != 0});
      chk("m_res_valid",   {31'b0, res_valid},   {31'b0, m_phase == NIB + 1});
      chk("m_result",      {16'b0, result},      {16'b0, m_res});
      chk("m_cout",        {31'b0, cout},        {31'b0, m_cout});
      chk("m_ovf",         {31'b0, ovf},         {31'b0, m_ovf});
    end
  end

  // Issue one command and wait for its result; leaves res_valid pending.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] e_res, input logic e_cout, input logic e_ovf,
                       input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_before"}, {31'b0, start_ready}, 32'd1);
    start_valid = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    while (!res_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, NIB);
    chk({tag, "_result"},  {16'b0, result}, {16'b0, e_res});
    chk({tag, "_cout"},    {31'b0, cout},   {31'b0, e_cout});
    chk({tag, "_ovf"},     {31'b0, ovf},    {31'b0, e_ovf});
  endtask

  task automatic retire();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("retire_start_ready", {31'b0, start_ready}, 32'd1);
  endtask

  logic [W-1:0] bb_a [3] = '{16'h1111, 16'h9000, 16'h00FF};
  logic [W-1:0] bb_b [3] = '{16'h2222, 16'h1000, 16'hFF01};
  logic         bb_s [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] bb_r [3] = '{16'h3333, 16'h8000, 16'h0000};

  initial begin
    int t_acc [3];
    int guard;
    rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; res_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", {31'b0, start_ready}, 32'd0);
    chk("rst_result",      {16'b0, result},      32'd0);
    chk("rst_res_valid",   {31'b0, res_valid},   32'd0);
    chk("rst_busy",        {31'b0, busy},        32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, start_ready}, 32'd1);

    issue(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, "add"); retire();
    issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"); retire();
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add"); retire();
    issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub"); retire();
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap"); retire();

    // Backpressure: result must hold while the requester side is noisy.
    issue(16'hA5A5, 16'h0F0F, 1'b1, 16'h9696, 1'b1, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      start_valid = ~start_valid; op_a = op_a + 16'h1357; op_b = op_b ^ 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      chk("bp_result_hold", {16'b0, result},      32'h9696);
      chk("bp_valid_hold",  {31'b0, res_valid},   32'd1);
      chk("bp_no_accept",   {31'b0, start_ready}, 32'd0);
    end
    start_valid = 1'b0;
    retire();
    chk("bp_result_after", {16'b0, result}, 32'h9696);

    // Reset on the second RUN cycle.
    @(negedge clk);
    start_valid = 1'b1; op_a = 16'h4444; op_b = 16'h1111; sub = 1'b0;
    @(posedge clk);
    @(negedge clk); start_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_result", {16'b0, result},      32'd0);
    chk("mid_rst_busy",   {31'b0, busy},        32'd0);
    #1;
    chk("mid_rst_ready",  {31'b0, start_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", {31'b0, res_valid}, 32'd0);
    end
    issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst"); retire();

    // Back-to-back with start_valid and res_ready held high.
    @(negedge clk);
    res_ready = 1'b1; start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op_a = bb_a[k]; op_b = bb_b[k]; sub = bb_s[k];
      guard = 0;
      while (!start_ready && guard < 20) begin
        @(negedge clk); guard++;
      end
      chk("b2b_accept_seen", {31'b0, start_ready}, 32'd1);
      t_acc[k] = cyc;
      @(posedge clk);
      @(negedge clk);
      if (k == 2) start_valid = 1'b0;
      op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~sub;
      guard = 0;
      while (!res_valid && guard < 20) begin
        @(negedge clk); guard++;
      end
      chk("b2b_result", {16'b0, result}, {16'b0, bb_r[k]});
    end
    chk("b2b_space_01", t_acc[1] - t_acc[0], NIB + 2);
    chk("b2b_space_12", t_acc[2] - t_acc[1], NIB + 2);
    repeat (4) @(negedge clk);
    res_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add or subtract by iterating one 4-bit adder/subtractor slice, one nibble per clock, LSB first.
- Ripples carry/borrow between nibbles in a register.
- Valid/ready handshake on the command and result sides.
- Sits between a requester (control FSM or bus front-end) and the shared nibble ALU; trades area for latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  command valid.
- start_ready  out  1  command accepted when start_valid & start_ready at an edge.
- op_a  in  WIDTH  minuend / augend; sampled only at accept.
- op_b  in  WIDTH  subtrahend / addend; sampled only at accept.
- sub  in  1  0 = add (a+b), 1 = subtract (a-b); sampled only at accept.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready; result retired on res_valid & res_ready.
- result  out  WIDTH  sum/difference modulo 2^WIDTH.
- cout  out  1  final carry; for sub, 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States:
  - IDLE: start_ready=1.
  - RUN: iterate nibbles.
  - DONE: res_valid=1, outputs held.
- IDLE -> RUN on accept. At the accept edge, latch op_a, op_b and sub; set carry_reg <= sub (two's-complement +1); set idx <= 0.
- RUN, each edge:
  - Slice inputs: a_nib = a[4*idx+3:4*idx], b_nib = b[...] ^ {4{sub}}, cin = carry_reg.
  - Write the sum nibble into the result register at position idx.
  - carry_reg <= slice cout; idx <= idx+1.
  - On the edge processing idx = NIB-1, go to DONE and register cout and ovf.
- Latency: res_valid rises exactly NIB cycles after the accept edge (4 for WIDTH=16).
- ovf = (a[W-1] == beff[W-1]) & (result[W-1] != a[W-1]), where beff = b ^ {W{sub}}.
- DONE -> IDLE on the res_valid & res_ready edge.
  - result, cout and ovf keep their values after retirement until the next DONE.
  - While res_valid=1 and res_ready=0, result, cout and ovf must not change.
- No overlap: start_ready=0 in RUN and DONE. Minimum command period is NIB+2 cycles.
- start_valid, op_a, op_b and sub are ignored whenever start_ready=0. Operand changes after accept do not affect the result.
- start_ready = (state==IDLE) & ~rst, so it is 0 during reset.
- Reset (any state, including mid-RUN or DONE):
  - At the next edge: state=IDLE, idx=0, carry_reg=0, result=0, cout=0, ovf=0, res_valid=0.
  - Any in-flight operation is discarded and produces no result.
  - busy=0, and start_ready=1 from the first cycle rst is low.
- WIDTH=4 degenerate case: a single RUN cycle.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}
  - NIB_W = 4
  - idx width function: clog2(WIDTH/4), minimum 1
- Sub-module: nibble_addsub_slice.
  - Ports: a[3:0], b[3:0], cin -> sum[3:0], cout.
  - Purely combinational 4-bit full-adder ripple chain; the controller applies the b inversion and drives cin.
  - Instantiated once; the controller owns all muxing and registers.

Test Plan (WIDTH=16):
- Add: a=0x1234, b=0x0FCD, sub=0 -> result=0x2201, cout=0, ovf=0; res_valid exactly 4 cycles after accept.
- Sub with borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0.
- Overflow: a=0x7FFF+b=0x0001 -> 0x8000, cout=0, ovf=1; then a=0x8000-b=0x0001 -> 0x7FFF, cout=1, ovf=1; then 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid while toggling op_a/op_b/start_valid -> result/cout/ovf stable, start_ready=0, no second accept; res_ready=1 -> retire, start_ready=1 next cycle.
- Reset mid-RUN: assert rst on 2nd RUN cycle for 1 cycle -> res_valid never rises for that command, result=0, busy=0, start_ready=1 after rst low; next command 0x0001+0x0001 -> 0x0002.
- Back-to-back: start_valid and res_ready held high, 3 commands -> accepts spaced exactly 6 cycles apart, results in order.
